// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int DIV_WIDTH = 32;

    // Bits needed to hold values 0..value-1; used to size the step counter.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remIn_i,
    input  logic             dividendBit_i,
    input  logic [WIDTH-1:0] divisorMag_i,
    output logic [WIDTH-1:0] remOut_o,
    output logic             quoBit_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             borrow;
    logic             unusedTrialBit;

    assign shifted        = {remIn_i, dividendBit_i};
    assign trial          = {1'b0, shifted} - {2'b00, divisorMag_i};
    assign borrow         = trial[WIDTH+1];
    assign unusedTrialBit = trial[WIDTH];

    // Either result is below the divisor magnitude, so the low WIDTH bits suffice.
    assign quoBit_o = ~borrow;
    assign remOut_o = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, signed or unsigned, one quotient bit per cycle.
// Optional macro SEQ_DIVIDER_ZERO_SKIP_EN shortens the run when the divisor is zero.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int               CW       = clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] partRem_q, partRem_d;
    logic [WIDTH-1:0] quoAcc_q, quoAcc_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] divisorMag_q, divisorMag_d;
    logic             signedOp_q, signedOp_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             divByZero_q, divByZero_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] stepRem;
    logic             stepBit;
    logic             negQuo, negRem;

    // MIN_INT maps onto itself, which is exactly 2^(WIDTH-1) read as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value,
                                                   input logic isSigned);
        return (isSigned && value[WIDTH-1]) ? -value : value;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .remIn_i      (partRem_q),
        .dividendBit_i(quoAcc_q[WIDTH-1]),
        .divisorMag_i (divisorMag_q),
        .remOut_o     (stepRem),
        .quoBit_o     (stepBit)
    );

    assign negQuo = signedOp_q && (dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1]);
    assign negRem = signedOp_q && dividend_q[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            partRem_q    <= '0;
            quoAcc_q     <= '0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            divisorMag_q <= '0;
            signedOp_q   <= 1'b0;
            quotient_q   <= '0;
            remainder_q  <= '0;
            divByZero_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            partRem_q    <= partRem_d;
            quoAcc_q     <= quoAcc_d;
            dividend_q   <= dividend_d;
            divisor_q    <= divisor_d;
            divisorMag_q <= divisorMag_d;
            signedOp_q   <= signedOp_d;
            quotient_q   <= quotient_d;
            remainder_q  <= remainder_d;
            divByZero_q  <= divByZero_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        partRem_d    = partRem_q;
        quoAcc_d     = quoAcc_q;
        dividend_d   = dividend_q;
        divisor_d    = divisor_q;
        divisorMag_d = divisorMag_q;
        signedOp_d   = signedOp_q;
        quotient_d   = quotient_q;
        remainder_d  = remainder_q;
        divByZero_d  = divByZero_q;
        overflow_d   = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dividend_d   = dividend;
                    divisor_d    = divisor;
                    signedOp_d   = signed_op;
                    partRem_d    = '0;
                    quoAcc_d     = magnitude(dividend, signed_op);
                    divisorMag_d = magnitude(divisor, signed_op);
                    count_d      = CNT_INIT;
`ifdef SEQ_DIVIDER_ZERO_SKIP_EN
                    // An empty counter makes CALC hand straight over to FIX.
                    if (divisor == '0) begin
                        count_d = '0;
                    end
`endif
                    state_d = CALC;
                end
            end
            CALC: begin
                if (count_q == '0) begin
                    state_d = FIX;
                end else begin
                    partRem_d = stepRem;
                    quoAcc_d  = {quoAcc_q[WIDTH-2:0], stepBit};
                    count_d   = count_q - 1'b1;
                end
            end
            FIX: begin
                if (divisor_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = dividend_q;
                    divByZero_d = 1'b1;
                    overflow_d  = 1'b0;
                end else begin
                    quotient_d  = negQuo ? -quoAcc_q : quoAcc_q;
                    remainder_d = negRem ? -partRem_q : partRem_q;
                    divByZero_d = 1'b0;
                    overflow_d  = signedOp_q && (dividend_q == MIN_INT) && (divisor_q == '1);
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = divByZero_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_seq_divider.sv
// Table-driven scoreboard bench for seq_divider, plus hand-written abort/ignore/back-to-back cases.
module tb_seq_divider;

    localparam int W = 32;

    typedef struct {
        logic          sgn;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [W-1:0]  q;
        logic [W-1:0]  r;
        logic          dbz;
        logic          ovf;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         signed_op = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[11];
    vec_t expQ[$];

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_op  (signed_op),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int expLatency(input vec_t v);
`ifdef SEQ_DIVIDER_ZERO_SKIP_EN
        return (v.b == '0) ? 2 : W + 2;
`else
        return W + 2;
`endif
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
    task automatic applyStimulus(input vec_t v);
        start     = 1'b1;
        signed_op = v.sgn;
        dividend  = v.a;
        divisor   = v.b;
        @(posedge clk);
        expQ.push_back(v);
        @(negedge clk);
        start = 1'b0;
        checkVal("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    // Waits (bounded) for done, optionally pulsing a stray start at edge injectAt, then scores.
    task automatic checkOutput(input int expLat, input int injectAt);
        int   edges;
        logic busyLow;
        vec_t e;
        edges   = 0;
        busyLow = 1'b0;
        while (edges < 200) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done) break;
            if (!busy) busyLow = 1'b1;
            if (edges == injectAt) begin
                start     = 1'b1;
                signed_op = 1'b0;
                dividend  = 32'd50;
                divisor   = 32'd5;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout actual=no_done required=done_within_200");
            if (expQ.size() > 0) void'(expQ.pop_front());
            return;
        end
        checkVal("latency", 32'(edges), 32'(expLat));
        checkVal("busy_held", {31'd0, busyLow}, 32'd0);
        checkVal("busy_at_done", {31'd0, busy}, 32'd1);
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard actual=empty required=entry");
            return;
        end
        e = expQ.pop_front();
        checkVal("quotient", quotient, e.q);
        checkVal("remainder", remainder, e.r);
        checkVal("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
        checkVal("overflow", {31'd0, overflow}, {31'd0, e.ovf});
        @(negedge clk);
        checkVal("done_pulse_end", {31'd0, done}, 32'd0);
        checkVal("busy_released", {31'd0, busy}, 32'd0);
    endtask

    // Main sequence: reset state, vector table, then the multi-cycle corner cases.
    initial begin
        int   sawDone;
        vec_t v;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0};
        vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b1};
        vecs[4]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 1'b0};
        vecs[5]  = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1'b0};
        vecs[6]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1'b0};
        vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0};
        vecs[8]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 1'b0};
        vecs[9]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1, 1'b0};
        vecs[10] = '{1'b0, 32'd6,          32'd3,          32'd2,          32'd0,          1'b0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("reset_busy", {31'd0, busy}, 32'd0);
        checkVal("reset_done", {31'd0, done}, 32'd0);
        checkVal("reset_quotient", quotient, 32'd0);
        checkVal("reset_remainder", remainder, 32'd0);
        checkVal("reset_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back: each new start lands in the first IDLE cycle after done.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(expLatency(vecs[i]), -1);
        end

        // Stray start mid-operation must not disturb the captured operands.
        applyStimulus(vecs[0]);
        checkOutput(expLatency(vecs[0]), 10);

        // Reset at edge 15 of 1000/3 aborts with no done.
        v = '{1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0};
        applyStimulus(v);
        repeat (15) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        expQ.delete();
        checkVal("abort_busy", {31'd0, busy}, 32'd0);
        checkVal("abort_done", {31'd0, done}, 32'd0);
        checkVal("abort_quotient", quotient, 32'd0);
        checkVal("abort_remainder", remainder, 32'd0);
        checkVal("abort_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sawDone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) sawDone = 1;
        end
        checkVal("abort_no_done", 32'(sawDone), 32'd0);

        applyStimulus(v);
        checkOutput(expLatency(v), -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
